ps_arbiter: RTL and testbench

//  Shares one ps_if slave (register file / memory) among NUM_REQ requesters.

---
 rtl/ps_arb_pkg.sv | 12 +
 rtl/ps_rr_picker.sv | 32 +++
 rtl/ps_arbiter.sv | 145 ++++++++++++++
 tb/tb_ps_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ps_arb_pkg.sv
// Shared types and helpers for the ps_if round-robin arbiter.
package ps_arb_pkg;

  typedef enum logic [1:0] {WR_IDLE, WR_GRANT, WR_WAIT_RESP} wr_state_e;
  typedef enum logic       {RD_IDLE, RD_BUSY}                rd_state_e;

  // Requester index k positions after base, wrapping at n.
  function automatic int rr_idx(input int base, input int k, input int n);
    return (base + k >= n) ? base + k - n : base + k;
  endfunction

endpackage

// File: rtl/ps_rr_picker.sv
// Combinational round-robin pick: first request at/after ptr, wrapping.
module ps_rr_picker
  import ps_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IW'(rr_idx(32'(i_ptr), k, N));
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

endmodule

// File: rtl/ps_arbiter.sv
// Shares one ps_if slave among NUM_REQ requesters; independent round-robin
// write and read channels, one outstanding transaction per channel.
module ps_arbiter
  import ps_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DEPTH      = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  bit WRESP_EN   = 1'b1,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_waddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_wdata,
  input  logic [NUM_REQ-1:0]            s_wvalid,
  output logic [NUM_REQ-1:0]            s_wready,
  output logic [NUM_REQ-1:0]            s_wresp,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_raddr,
  input  logic [NUM_REQ-1:0]            s_arvalid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] s_rdata,
  output logic [NUM_REQ-1:0]            s_rvalid,
  input  logic [NUM_REQ-1:0]            s_rready,
  output logic [ADDR_WIDTH-1:0]         m_waddr,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  input  logic                          m_wresp,
  output logic [ADDR_WIDTH-1:0]         m_raddr,
  output logic                          m_arvalid,
  output logic                          m_rready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic                          m_rvalid
);

  localparam int IW = $clog2(NUM_REQ);

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] g);
    return (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  wr_state_e             r_wst;
  rd_state_e             r_rst;
  logic [IW-1:0]         r_wg, r_wptr, r_rg, r_rptr;
  logic [NUM_REQ-1:0]    r_wgnt, r_rgnt;
  logic [NUM_REQ-1:0]    w_wpick, w_rpick;
  logic [IW-1:0]         w_widx, w_ridx;
  logic                  w_wany, w_rany;
  logic                  w_wsel_valid, w_rsel_valid, w_rsel_rready;
  logic                  w_wdone, w_rdone;

  ps_rr_picker #(.N(NUM_REQ)) u_wpick (
    .i_req(s_wvalid), .i_ptr(r_wptr), .o_grant(w_wpick), .o_idx(w_widx), .o_any(w_wany)
  );
  ps_rr_picker #(.N(NUM_REQ)) u_rpick (
    .i_req(s_arvalid), .i_ptr(r_rptr), .o_grant(w_rpick), .o_idx(w_ridx), .o_any(w_rany)
  );

  // Slice muxes steered by the registered grant index.
  always_comb begin
    m_waddr       = '0;
    m_wdata       = '0;
    m_raddr       = '0;
    w_wsel_valid  = 1'b0;
    w_rsel_valid  = 1'b0;
    w_rsel_rready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_wg == IW'(i)) begin
        m_waddr      = s_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_wdata      = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_wsel_valid = s_wvalid[i];
      end
      if (r_rg == IW'(i)) begin
        m_raddr       = s_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_rsel_valid  = s_arvalid[i];
        w_rsel_rready = s_rready[i];
      end
    end
  end

  assign m_wvalid  = (r_wst == WR_GRANT) && w_wsel_valid;
  assign s_wready  = (r_wst == WR_GRANT)     ? (r_wgnt & {NUM_REQ{m_wready}}) : '0;
  assign s_wresp   = (r_wst == WR_WAIT_RESP) ? (r_wgnt & {NUM_REQ{m_wresp}})  : '0;
  assign w_wdone   = m_wvalid && m_wready;

  assign m_arvalid = (r_rst == RD_BUSY) && w_rsel_valid;
  assign m_rready  = (r_rst == RD_BUSY) && w_rsel_rready;
  assign s_rvalid  = (r_rst == RD_BUSY) ? (r_rgnt & {NUM_REQ{m_rvalid}}) : '0;
  assign s_rdata   = {NUM_REQ{m_rdata}};
  assign w_rdone   = m_rvalid && m_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wst  <= WR_IDLE;
      r_wg   <= '0;
      r_wgnt <= '0;
      r_wptr <= '0;
    end else begin
      case (r_wst)
        WR_IDLE: if (w_wany) begin
          r_wg   <= w_widx;
          r_wgnt <= w_wpick;
          r_wst  <= WR_GRANT;
        end
        WR_GRANT: begin
          if (w_wdone) begin
            r_wptr <= nxt(r_wg);
            r_wst  <= WRESP_EN ? WR_WAIT_RESP : WR_IDLE;
          end else if (!w_wsel_valid) begin
            r_wst  <= WR_IDLE;  // requester withdrew: release, pointer untouched
          end
        end
        WR_WAIT_RESP: if (m_wresp) r_wst <= WR_IDLE;
        default: r_wst <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst  <= RD_IDLE;
      r_rg   <= '0;
      r_rgnt <= '0;
      r_rptr <= '0;
    end else begin
      case (r_rst)
        RD_IDLE: if (w_rany) begin
          r_rg   <= w_ridx;
          r_rgnt <= w_rpick;
          r_rst  <= RD_BUSY;
        end
        RD_BUSY: begin
          if (w_rdone) begin
            r_rptr <= nxt(r_rg);
            r_rst  <= RD_IDLE;
          end else if (!w_rsel_valid) begin
            r_rst  <= RD_IDLE;
          end
        end
        default: r_rst <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_arbiter.sv
// Directed + randomized bench for ps_arbiter against a per-cycle reference model.
module tb_ps_arbiter;
  localparam int N = 4, DEPTH = 32, AW = 5, DW = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] wa [N];
  logic [AW-1:0] ra [N];
  logic [DW-1:0] wd [N];
  logic [N*AW-1:0] s_waddr, s_raddr;
  logic [N*DW-1:0] s_wdata, s_rdata;
  logic [N-1:0]    s_wvalid, s_wready, s_wresp, s_arvalid, s_rvalid, s_rready;
  logic [AW-1:0]   m_waddr, m_raddr;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic            m_wvalid, m_wready, m_wresp, m_arvalid, m_rready, m_rvalid;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign s_waddr[i*AW +: AW] = wa[i];
    assign s_raddr[i*AW +: AW] = ra[i];
    assign s_wdata[i*DW +: DW] = wd[i];
  end

  ps_arbiter #(.NUM_REQ(N), .DEPTH(DEPTH), .DATA_WIDTH(DW), .WRESP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_wresp(s_wresp), .s_raddr(s_raddr), .s_arvalid(s_arvalid), .s_rdata(s_rdata),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wresp(m_wresp), .m_raddr(m_raddr), .m_arvalid(m_arvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid)
  );

  // Reference model: write phase 0=free 1=owned 2=awaiting resp; read owned flag.
  int wph, wown, wptr, rbusy, rown, rptr;
  int n_assert = 0, n_fail = 0;
  int dut_wq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    wph = 0; wown = 0; wptr = 0; rbusy = 0; rown = 0; rptr = 0;
  endtask

  task automatic check_outputs();
    logic own_wv;
    own_wv = (wph == 1) && s_wvalid[wown];
    chk("m_wvalid", 64'(m_wvalid), 64'(own_wv));
    chk("s_wready", 64'(s_wready), (wph == 1 && m_wready) ? 64'd1 << wown : 64'd0);
    chk("s_wresp",  64'(s_wresp),  (wph == 2 && m_wresp)  ? 64'd1 << wown : 64'd0);
    if (own_wv) begin
      chk("m_waddr", 64'(m_waddr), 64'(wa[wown]));
      chk("m_wdata", 64'(m_wdata), 64'(wd[wown]));
    end
    chk("m_arvalid", 64'(m_arvalid), 64'(rbusy != 0 && s_arvalid[rown]));
    chk("m_rready",  64'(m_rready),  64'(rbusy != 0 && s_rready[rown]));
    chk("s_rvalid",  64'(s_rvalid),  (rbusy != 0 && m_rvalid) ? 64'd1 << rown : 64'd0);
    if (rbusy != 0 && s_arvalid[rown]) chk("m_raddr", 64'(m_raddr), 64'(ra[rown]));
    for (int i = 0; i < N; i++) chk("s_rdata", 64'(s_rdata[i*DW +: DW]), 64'(m_rdata));
  endtask

  task automatic model_update();
    int w;
    if (!rst_n) begin model_reset(); return; end
    case (wph)
      0: begin w = pick(s_wvalid, wptr); if (w >= 0) begin wown = w; wph = 1; end end
      1: if (s_wvalid[wown] && m_wready) begin wptr = (wown + 1) % N; wph = 2; end
         else if (!s_wvalid[wown]) wph = 0;
      default: if (m_wresp) wph = 0;
    endcase
    if (rbusy == 0) begin
      w = pick(s_arvalid, rptr);
      if (w >= 0) begin rown = w; rbusy = 1; end
    end else if (m_rvalid && s_rready[rown]) begin
      rptr = (rown + 1) % N; rbusy = 0;
    end else if (!s_arvalid[rown]) rbusy = 0;
  endtask

  // Inputs are driven at negedge; check 1ns later, advance model on posedge.
  task automatic step();
    #1;
    check_outputs();
    for (int i = 0; i < N; i++) if (s_wvalid[i] && s_wready[i]) dut_wq.push_back(i);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic quiesce();
    s_wvalid = '0; s_arvalid = '0; s_rready = '0;
    m_wready = 1'b0; m_rvalid = 1'b0; m_wresp = 1'b1;
    step(); step();
    m_wresp = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) begin
      wa[i] = AW'(i); ra[i] = AW'(i); wd[i] = DW'(32'h1111_1111 * (i + 1));
    end
    s_wvalid = '1; s_arvalid = '0; s_rready = '0;
    m_wready = 1'b1; m_wresp = 1'b1; m_rvalid = 1'b0; m_rdata = '0;
    @(negedge clk);

    // Reset held with every requester asking; then fairness over 20 writes.
    step(); step();
    rst_n = 1'b1;
    dut_wq.delete();
    step();
    #1 chk("first_grant", 64'(s_wready), 64'h1);
    for (int c = 0; c < 63; c++) step();
    chk("rr_count", 64'(dut_wq.size() >= 20), 64'd1);
    for (int k = 0; k < 20 && k < dut_wq.size(); k++) chk("rr_order", 64'(dut_wq[k]), 64'(k % N));
    quiesce();

    // Single write from requester 2.
    wa[2] = 5'd5; wd[2] = 32'hDEAD_BEEF; s_wvalid = 4'b0100; m_wready = 1'b1;
    step();
    #1 chk("w_valid", 64'(m_wvalid), 64'd1);
    chk("w_addr", 64'(m_waddr), 64'd5);
    chk("w_data", 64'(m_wdata), 64'hDEAD_BEEF);
    chk("w_ready", 64'(s_wready), 64'b0100);
    step();
    s_wvalid = '0;
    step();
    m_wresp = 1'b1;
    #1 chk("w_resp", 64'(s_wresp), 64'b0100);
    step();
    m_wresp = 1'b0;

    // Read with requester back-pressure, then rd_ptr must point at 2.
    ra[1] = 5'd7; s_arvalid = 4'b0010; m_rvalid = 1'b1; m_rdata = 32'h1234; s_rready = '0;
    step();
    for (int c = 0; c < 3; c++) begin
      #1 chk("rd_hold", 64'({s_rvalid, m_rready, m_raddr}), 64'({4'b0010, 1'b0, 5'd7}));
      step();
    end
    s_rready[1] = 1'b1;
    step();
    ra[0] = 5'd10; ra[2] = 5'd12; ra[3] = 5'd13;
    s_arvalid = 4'b1101; s_rready = '0;
    step();
    #1 chk("rd_ptr", 64'({s_rvalid, m_raddr}), 64'({4'b0100, 5'd12}));
    quiesce();

    // Both channels owned by requester 0; stalled write must not delay read.
    s_wvalid = 4'b0001; s_arvalid = 4'b0001; s_rready = 4'b0001; m_rvalid = 1'b1; m_wready = 1'b0;
    step();
    #1 chk("concurrent", 64'({m_wvalid, s_rvalid}), 64'({1'b1, 4'b0001}));
    step();
    s_arvalid = '0;
    for (int c = 0; c < 3; c++) step();
    m_wready = 1'b1;
    step();
    quiesce();

    // Reset during GRANT drops m_wvalid at once.
    s_wvalid = 4'b0100; m_wready = 1'b0;
    step();
    async_reset();
    // Reset during WAIT_RESP abandons the write and clears wr_ptr.
    m_wready = 1'b1;
    step(); step();
    s_wvalid = '0;
    async_reset();
    m_wresp = 1'b1;
    #1 chk("stale_wresp", 64'(s_wresp), 64'd0);
    step();
    m_wresp = 1'b0; s_wvalid = '1;
    step();
    #1 chk("ptr_after_rst", 64'(s_wready), 64'h1);
    quiesce();

    // Randomized traffic, including requesters that withdraw early.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (s_wvalid[i]) s_wvalid[i] = ($urandom_range(0, 15) != 0);
        else begin
          s_wvalid[i] = ($urandom_range(0, 2) == 0);
          wa[i] = AW'($urandom_range(0, DEPTH - 1)); wd[i] = $urandom;
        end
        if (s_arvalid[i]) s_arvalid[i] = ($urandom_range(0, 15) != 0);
        else begin
          s_arvalid[i] = ($urandom_range(0, 2) == 0);
          ra[i] = AW'($urandom_range(0, DEPTH - 1));
        end
        s_rready[i] = $urandom_range(0, 1) != 0;
      end
      m_wready = $urandom_range(0, 1) != 0;
      m_wresp  = $urandom_range(0, 2) == 0;
      m_rvalid = $urandom_range(0, 1) != 0;
      m_rdata  = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
